// File: rtl/coprocessor0_params_pkg.sv
// Shared CP0 types and constants: register addresses, reset values,
// Status/Cause field layouts and the write-back / fetch interface structs.
package coprocessor0_params;

    localparam int CPU_DATA_WIDTH = 32;

    // CP0 register numbers (select 0)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Register reset values
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] CAUSE_RESET  = 32'h0000_0000;

    // Status register layout: BEV is hard-wired to 1
    typedef struct packed {
        logic [8:0] zero_hi;
        logic       bev;
        logic [5:0] zero_mid;
        logic [7:0] im;
        logic [5:0] zero_lo;
        logic       exl;
        logic       ie;
    } StatusData;

    // Cause register layout
    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_hi;
        logic [7:0]  ip;
        logic        zero_mid;
        logic [4:0]  exc_code;
        logic [1:0]  zero_lo;
    } CauseData;

    // Request from write-back. Every field is qualified per cycle: a
    // request (write_enable, exception_valid, eret_flush) is present for
    // exactly one clock and is consumed at the next rising edge; there is
    // no back-pressure, CP0 always accepts.
    typedef struct packed {
        logic [4:0]                address_register;
        logic [2:0]                address_select;
        logic                      write_enable;
        logic [CPU_DATA_WIDTH-1:0] write_data;
        logic                      exception_valid;
        logic [4:0]                exception_code;
        logic [CPU_DATA_WIDTH-1:0] exception_address;
        logic                      in_delay_slot;
        logic                      is_address_fault;
        logic [CPU_DATA_WIDTH-1:0] badvaddr_value;
        logic                      eret_flush;
    } WBToCP0Data;

    // Redirect target and gated pending interrupts for instruction fetch
    typedef struct packed {
        logic [CPU_DATA_WIDTH-1:0] exception_address;
        logic [7:0]                interrupt_valid;
    } CP0ToIFData;

    // Compose the architectural Status word from its stored fields
    function automatic logic [31:0] pack_status(input logic [7:0] im,
                                                input logic exl,
                                                input logic ie);
        StatusData s;
        s     = StatusData'(STATUS_RESET);
        s.im  = im;
        s.exl = exl;
        s.ie  = ie;
        return 32'(s);
    endfunction

    // Compose the architectural Cause word from its stored fields
    function automatic logic [31:0] pack_cause(input logic bd,
                                               input logic ti,
                                               input logic [7:0] ip,
                                               input logic [4:0] exc_code);
        CauseData c;
        c          = CauseData'(CAUSE_RESET);
        c.bd       = bd;
        c.ti       = ti;
        c.ip       = ip;
        c.exc_code = exc_code;
        return 32'(c);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: a free-running tick divider advances Count every
// COUNT_DIVIDE clocks; TI latches when an increment lands on Compare.
module cp0_timer
    import coprocessor0_params::*;
#(
    parameter int COUNT_DIVIDE = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      count_we,
    input  logic                      compare_we,
    input  logic [CPU_DATA_WIDTH-1:0] write_data,
    output logic [CPU_DATA_WIDTH-1:0] count,
    output logic [CPU_DATA_WIDTH-1:0] compare,
    output logic                      ti
);

    // With COUNT_DIVIDE == 1 the divider stays at 0 and ticks every cycle.
    localparam int DIV_W = (COUNT_DIVIDE > 1) ? $clog2(COUNT_DIVIDE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIVIDE - 1);

    logic [DIV_W-1:0]          div;
    logic                      tick;
    logic [CPU_DATA_WIDTH-1:0] count_inc;
    logic                      hit;

    assign tick      = (div == DIV_LAST);
    assign count_inc = count + 1'b1;   // wraps silently past all-ones
    // Only a real increment can raise TI; a software write to Count cannot.
    assign hit       = tick && !count_we && (count_inc == compare);

    // Divider phase: wraps on tick, restarts when software writes Count
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            div <= '0;
        else if (count_we || tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    // Count: a software write overrides a coincident tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (count_we)
            count <= write_data;
        else if (tick)
            count <= count_inc;
    end

    // Compare: software-written only
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            compare <= '0;
        else if (compare_we)
            compare <= write_data;
    end

    // Timer interrupt flag: writing Compare acknowledges it, even on a match
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ti <= 1'b0;
        else if (compare_we)
            ti <= 1'b0;
        else if (hit)
            ti <= 1'b1;
    end

endmodule

// File: rtl/coprocessor0_core.sv
// CP0 register file and exception/interrupt controller beside write-back.
// Holds BadVAddr, Count, Compare, Status, Cause, EPC; commits exceptions and
// ERET; reports the fetch redirect target and the gated pending interrupts.
module coprocessor0_core
    import coprocessor0_params::*;
#(
    parameter int          HW_INT_COUNT     = 6,
    parameter int          COUNT_DIVIDE     = 2,
    parameter int          TIMER_INT_LINE   = 5,
    parameter logic [31:0] EXCEPTION_VECTOR = 32'hbfc0_0380
) (
    input  logic                      clock,
    input  logic                      reset,
    input  WBToCP0Data                wb_to_cp0,
    input  logic [HW_INT_COUNT-1:0]   hw_interrupt,
    output logic [CPU_DATA_WIDTH-1:0] read_data,
    output CP0ToIFData                cp0_to_if,
    output logic                      interrupt_pending
);

    // Stored Status fields (BEV is constant)
    logic [7:0] status_im;
    logic       status_exl;
    logic       status_ie;

    // Stored Cause fields; IP[7:2] is rebuilt from hw_q and TI
    logic                    cause_bd;
    logic [4:0]              cause_exc_code;
    logic [1:0]              sw_ip;
    logic [HW_INT_COUNT-1:0] hw_q;

    logic [CPU_DATA_WIDTH-1:0] epc;
    logic [CPU_DATA_WIDTH-1:0] badvaddr;

    // Timer outputs
    logic [CPU_DATA_WIDTH-1:0] count;
    logic [CPU_DATA_WIDTH-1:0] compare;
    logic                      ti;

    // Decoded requests
    logic      exc;
    logic      eret;
    logic      mtc0;
    logic      we_count;
    logic      we_compare;
    logic      we_status;
    logic      we_cause;
    logic      we_epc;
    StatusData wr_status;
    CauseData  wr_cause;

    logic [5:0] hw_pad;
    logic [5:0] timer_line;
    logic [7:0] ip;
    logic [7:0] int_masked;

    assign exc  = wb_to_cp0.exception_valid;
    assign eret = wb_to_cp0.eret_flush;
    // A committing exception squashes any MTC0 carried in the same cycle.
    assign mtc0 = wb_to_cp0.write_enable && !exc &&
                  (wb_to_cp0.address_select == 3'd0);

    assign we_count   = mtc0 && (wb_to_cp0.address_register == CP0_COUNT);
    assign we_compare = mtc0 && (wb_to_cp0.address_register == CP0_COMPARE);
    assign we_status  = mtc0 && (wb_to_cp0.address_register == CP0_STATUS);
    assign we_cause   = mtc0 && (wb_to_cp0.address_register == CP0_CAUSE);
    assign we_epc     = mtc0 && (wb_to_cp0.address_register == CP0_EPC);

    assign wr_status = StatusData'(wb_to_cp0.write_data);
    assign wr_cause  = CauseData'(wb_to_cp0.write_data);

    cp0_timer #(
        .COUNT_DIVIDE (COUNT_DIVIDE)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .count_we   (we_count),
        .compare_we (we_compare),
        .write_data (wb_to_cp0.write_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Status: exception sets EXL and wins over ERET and MTC0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_im  <= '0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (exc) begin
            status_exl <= 1'b1;
        end else if (we_status) begin
            status_im  <= wr_status.im;
            status_exl <= wr_status.exl;
            status_ie  <= wr_status.ie;
        end else if (eret) begin
            status_exl <= 1'b0;
        end
    end

    // Cause: ExcCode always loads on exception, BD only on a first-level one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cause_bd       <= 1'b0;
            cause_exc_code <= '0;
        end else if (exc) begin
            cause_exc_code <= wb_to_cp0.exception_code;
            if (!status_exl)
                cause_bd <= wb_to_cp0.in_delay_slot;
        end
    end

    // Software interrupt bits IP[1:0]
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sw_ip <= '0;
        else if (we_cause)
            sw_ip <= wr_cause.ip[1:0];
    end

    // Hardware interrupt sampling, one register stage from the pins
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            hw_q <= '0;
        else
            hw_q <= hw_interrupt;
    end

    // EPC: captured only when not already in exception level
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            epc <= '0;
        else if (exc) begin
            if (!status_exl)
                epc <= wb_to_cp0.in_delay_slot ?
                       (wb_to_cp0.exception_address - 32'd4) :
                       wb_to_cp0.exception_address;
        end else if (we_epc)
            epc <= wb_to_cp0.write_data;
    end

    // BadVAddr: hardware-written on address faults only
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            badvaddr <= '0;
        else if (exc && wb_to_cp0.is_address_fault)
            badvaddr <= wb_to_cp0.badvaddr_value;
    end

    // Interrupt pending bits: unused hardware lines read 0, TI joins its line
    assign hw_pad     = 6'(hw_q);
    assign timer_line = 6'(ti) << TIMER_INT_LINE;
    assign ip         = {hw_pad | timer_line, sw_ip};
    assign int_masked = (ip & status_im) & {8{status_ie & ~status_exl}};

    assign interrupt_pending           = |int_masked;
    assign cp0_to_if.interrupt_valid   = int_masked;
    assign cp0_to_if.exception_address = eret ? epc : EXCEPTION_VECTOR;

    // Combinational MFC0 read mux; unmapped registers and selects read 0
    always_comb begin
        read_data = '0;
        if (wb_to_cp0.address_select == 3'd0) begin
            case (wb_to_cp0.address_register)
                CP0_BADVADDR: read_data = badvaddr;
                CP0_COUNT:    read_data = count;
                CP0_COMPARE:  read_data = compare;
                CP0_STATUS:   read_data = pack_status(status_im, status_exl, status_ie);
                CP0_CAUSE:    read_data = pack_cause(cause_bd, ti, ip, cause_exc_code);
                CP0_EPC:      read_data = epc;
                default:      read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_coprocessor0_core.sv
// Directed bench for coprocessor0_core with an expected-value queue.
module tb_coprocessor0_core;
    import coprocessor0_params::*;

    logic             clock;
    logic             reset;
    WBToCP0Data       wb;
    logic [5:0]       hw_interrupt;
    logic [31:0]      read_data;
    CP0ToIFData       cp0_to_if;
    logic             interrupt_pending;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    coprocessor0_core #(
        .HW_INT_COUNT     (6),
        .COUNT_DIVIDE     (2),
        .TIMER_INT_LINE   (5),
        .EXCEPTION_VECTOR (32'hbfc0_0380)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .wb_to_cp0         (wb),
        .hw_interrupt      (hw_interrupt),
        .read_data         (read_data),
        .cp0_to_if         (cp0_to_if),
        .interrupt_pending (interrupt_pending)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #50 clock = ~clock;
    end

    // scoreboard compare
    task automatic check_equal(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic clear_wb();
        wb = '0;
    endtask

    task automatic expect_read(input string tag, input logic [4:0] addr,
                               input logic [31:0] exp);
        exp_q.push_back(exp);
        wb.address_register = addr;
        wb.address_select   = 3'd0;
        #1;
        check_equal(tag, read_data, exp_q.pop_front());
    endtask

    task automatic expect_pending(input string tag, input logic exp);
        exp_q.push_back(32'(exp));
        #1;
        check_equal(tag, 32'(interrupt_pending), exp_q.pop_front());
    endtask

    task automatic expect_ivalid(input string tag, input logic [7:0] exp);
        exp_q.push_back(32'(exp));
        #1;
        check_equal(tag, 32'(cp0_to_if.interrupt_valid), exp_q.pop_front());
    endtask

    task automatic expect_redirect(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        #1;
        check_equal(tag, cp0_to_if.exception_address, exp_q.pop_front());
    endtask

    // MTC0 for one cycle; starts and ends just after a falling edge
    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        wb.address_register = addr;
        wb.address_select   = 3'd0;
        wb.write_enable     = 1'b1;
        wb.write_data       = data;
        @(negedge clock);
        clear_wb();
    endtask

    task automatic drive_exception(input logic [31:0] addr, input logic ds,
                                   input logic [4:0] code, input logic fault,
                                   input logic [31:0] bva);
        wb.exception_valid   = 1'b1;
        wb.exception_address = addr;
        wb.in_delay_slot     = ds;
        wb.exception_code    = code;
        wb.is_address_fault  = fault;
        wb.badvaddr_value    = bva;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset        = 1'b1;
        hw_interrupt = '0;
        clear_wb();
        wait_cycles(2);
        reset = 1'b0;

        // reset state
        expect_read("rst_status", CP0_STATUS, 32'h0040_0000);
        expect_read("rst_count", CP0_COUNT, 32'h0);
        expect_read("rst_cause", CP0_CAUSE, 32'h0);
        expect_read("rst_epc", CP0_EPC, 32'h0);
        expect_read("rst_badvaddr", CP0_BADVADDR, 32'h0);
        expect_read("rst_compare", CP0_COMPARE, 32'h0);
        expect_pending("rst_pending", 1'b0);
        expect_ivalid("rst_ivalid", 8'h00);

        // Count advances once every two clocks
        wait_cycles(1);
        expect_read("count_after1", CP0_COUNT, 32'h0);
        wait_cycles(1);
        expect_read("count_after2", CP0_COUNT, 32'h1);

        // Compare match at Count == 5
        mtc0(CP0_COUNT, 32'h0);
        mtc0(CP0_COMPARE, 32'h5);
        wait_cycles(8);
        expect_read("count_before_match", CP0_COUNT, 32'h4);
        expect_read("cause_before_match", CP0_CAUSE, 32'h0);
        wait_cycles(1);
        expect_read("count_at_match", CP0_COUNT, 32'h5);
        expect_read("cause_ti_ip7", CP0_CAUSE, 32'h4000_8000);
        expect_ivalid("ivalid_masked_im0", 8'h00);
        mtc0(CP0_COMPARE, 32'h0);
        expect_read("cause_ti_cleared", CP0_CAUSE, 32'h0);
        expect_read("compare_zero", CP0_COMPARE, 32'h0);

        // Count write on a tick edge: written value wins, divider restarts
        mtc0(CP0_COUNT, 32'd100);
        expect_read("count_write_wins", CP0_COUNT, 32'd100);
        wait_cycles(1);
        expect_read("count_phase_restart", CP0_COUNT, 32'd100);
        wait_cycles(1);
        expect_read("count_after_restart", CP0_COUNT, 32'd101);

        // first-level exception in a delay slot with an address fault
        drive_exception(32'hbfc0_1000, 1'b1, 5'd4, 1'b1, 32'h1234_5677);
        @(negedge clock);
        clear_wb();
        expect_read("exc1_epc", CP0_EPC, 32'hbfc0_0ffc);
        expect_read("exc1_cause", CP0_CAUSE, 32'h8000_0010);
        expect_read("exc1_badvaddr", CP0_BADVADDR, 32'h1234_5677);
        expect_read("exc1_status", CP0_STATUS, 32'h0040_0002);

        // nested exception: EPC/BD/BadVAddr hold, ExcCode updates
        drive_exception(32'h1000_0000, 1'b0, 5'd5, 1'b0, 32'hdead_beef);
        @(negedge clock);
        clear_wb();
        expect_read("exc2_epc", CP0_EPC, 32'hbfc0_0ffc);
        expect_read("exc2_cause", CP0_CAUSE, 32'h8000_0014);
        expect_read("exc2_badvaddr", CP0_BADVADDR, 32'h1234_5677);

        // ERET redirects to EPC in its own cycle, clears EXL afterwards
        expect_redirect("redirect_vector", 32'hbfc0_0380);
        wb.eret_flush = 1'b1;
        expect_redirect("redirect_eret", 32'hbfc0_0ffc);
        @(negedge clock);
        clear_wb();
        expect_read("eret_status", CP0_STATUS, 32'h0040_0000);

        // hardware interrupt 0 through IM[2] with IE
        mtc0(CP0_STATUS, 32'h0000_0401);
        expect_read("status_im2_ie", CP0_STATUS, 32'h0040_0401);
        expect_pending("pending_no_hw", 1'b0);
        hw_interrupt = 6'b000001;
        expect_pending("pending_same_cycle", 1'b0);
        @(negedge clock);
        expect_pending("pending_hw0", 1'b1);
        expect_ivalid("ivalid_hw0", 8'h04);
        expect_read("cause_ip2", CP0_CAUSE, 32'h8000_0414);
        mtc0(CP0_STATUS, 32'h0000_0403);
        expect_pending("pending_exl_blocks", 1'b0);
        expect_ivalid("ivalid_exl_blocks", 8'h00);
        mtc0(CP0_STATUS, 32'h0000_0401);
        expect_pending("pending_restored", 1'b1);

        // exception and MTC0 Status together: exception wins
        drive_exception(32'h8000_0100, 1'b0, 5'd0, 1'b0, 32'h0);
        wb.address_register = CP0_STATUS;
        wb.write_enable     = 1'b1;
        wb.write_data       = 32'h0000_ff00;
        @(negedge clock);
        clear_wb();
        expect_read("exc_mtc0_status", CP0_STATUS, 32'h0040_0403);
        expect_read("exc_mtc0_epc", CP0_EPC, 32'h8000_0100);
        expect_read("exc_mtc0_cause", CP0_CAUSE, 32'h0000_0400);
        expect_pending("exc_mtc0_pending", 1'b0);

        // exception and ERET together: EXL stays set, EPC held
        drive_exception(32'h9000_0000, 1'b1, 5'd3, 1'b0, 32'h0);
        wb.eret_flush = 1'b1;
        expect_redirect("redirect_eret_exc", 32'h8000_0100);
        @(negedge clock);
        clear_wb();
        expect_read("exc_eret_status", CP0_STATUS, 32'h0040_0403);
        expect_read("exc_eret_cause", CP0_CAUSE, 32'h0000_040c);
        expect_read("exc_eret_epc", CP0_EPC, 32'h8000_0100);

        // Cause writes only reach IP[1:0]; BadVAddr is read-only
        mtc0(CP0_CAUSE, 32'hffff_ffff);
        expect_read("cause_sw_ip", CP0_CAUSE, 32'h0000_070c);
        mtc0(CP0_BADVADDR, 32'h0);
        expect_read("badvaddr_ro", CP0_BADVADDR, 32'h1234_5677);
        mtc0(CP0_EPC, 32'h0000_abcd);
        expect_read("epc_write", CP0_EPC, 32'h0000_abcd);
        expect_read("unmapped_reg", 5'd10, 32'h0);
        wb.address_select = 3'd1;
        exp_q.push_back(32'h0);
        wb.address_register = CP0_STATUS;
        #1;
        check_equal("unmapped_select", read_data, exp_q.pop_front());
        clear_wb();

        // asynchronous reset mid-run
        #5;
        reset = 1'b1;
        expect_read("mid_rst_status", CP0_STATUS, 32'h0040_0000);
        expect_read("mid_rst_count", CP0_COUNT, 32'h0);
        expect_read("mid_rst_epc", CP0_EPC, 32'h0);
        expect_pending("mid_rst_pending", 1'b0);
        @(negedge clock);
        expect_read("mid_rst_cause_held", CP0_CAUSE, 32'h0);
        reset        = 1'b0;
        hw_interrupt = '0;
        wait_cycles(1);
        expect_read("post_rst_count0", CP0_COUNT, 32'h0);
        wait_cycles(1);
        expect_read("post_rst_count1", CP0_COUNT, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
